// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, constants and the fetch-buffer entry type for the
// instruction-fetch front end.
package inst_fetch_unit_pkg;

    localparam int ADDR_LEN  = 32;
    localparam int INSTR_LEN = 32;

    localparam logic [INSTR_LEN-1:0] NOP_INST         = 32'h0000_0000;
    localparam logic [ADDR_LEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_LEN-1:0]  pc;
        logic [INSTR_LEN-1:0] inst;
    } fetch_entry_t;

    // Unused slots hold this value so an empty head reads as NOP at address 0.
    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, inst: NOP_INST};

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Shift-register fetch buffer: slot 0 is always the head, so the head is a
// register and needs no read mux. Flush and reset clear every slot.
module fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_count;
    fetch_entry_t  r_mem [DEPTH];
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_wr_idx;

    assign o_empty  = (r_count == CW'(0));
    assign o_full   = (r_count == CW'(DEPTH));
    assign w_pop    = i_pop & ~o_empty;
    assign w_push   = i_push & (~o_full | w_pop);
    // A new entry lands just above the surviving entries after any shift.
    assign w_wr_idx = r_count - CW'(w_pop);
    assign o_head   = r_mem[0];

    // Slot/count update; flush outranks push and pop.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_count <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= EMPTY_ENTRY;
            end
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (CW'(i) == w_wr_idx)) begin
                    r_mem[i] <= i_data;
                end else if (w_pop) begin
                    r_mem[i] <= (i == DEPTH - 1) ? EMPTY_ENTRY : r_mem[(i + 1) % DEPTH];
                end
            end
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: owns the PC, feeds the combinational
// instruction memory and buffers {pc, inst} pairs toward decode.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_LEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    output logic [ADDR_LEN-1:0]  imem_addr,
    input  logic [INSTR_LEN-1:0] imem_inst,
    input  logic                 redirect_valid,
    input  logic [ADDR_LEN-1:0]  redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_LEN-1:0] out_inst,
    output logic [ADDR_LEN-1:0]  out_pc,
    output logic [ADDR_LEN-1:0]  out_pc_plus4,
    output logic                 misalign_err
);

    logic [ADDR_LEN-1:0] r_pc;
    logic                r_misalign;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    fetch_entry_t        w_head;
    fetch_entry_t        w_wr_data;

    assign w_pop     = ~w_empty & out_ready & ~redirect_valid;
    assign w_push    = fetch_en & ~redirect_valid & (~w_full | w_pop);
    assign w_wr_data = '{pc: r_pc, inst: imem_inst};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_wr_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem_addr    = r_pc;
    assign out_valid    = ~w_empty;
    assign out_inst     = w_head.inst;
    assign out_pc       = w_head.pc;
    assign out_pc_plus4 = w_head.pc + ADDR_LEN'(4);
    assign misalign_err = r_misalign;

    // PC advance/redirect and the one-cycle misaligned-target flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                r_pc <= {redirect_pc[ADDR_LEN-1:2], 2'b00};
            end else if (w_push) begin
                r_pc <= r_pc + ADDR_LEN'(4);
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table, a wrap-around instance,
// and random traffic against a queue-based reference model.
module tb_inst_fetch_unit;

    localparam logic [31:0] W0  = 32'h012A_4020;
    localparam logic [31:0] W1  = 32'h014B_5822;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        misalign_err;

    logic [31:0] w_addr;
    logic [31:0] w_inst;
    logic        w_valid;
    logic [31:0] w_out_inst;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_pc_plus4;
    logic        w_mis;

    int total;
    int bad;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a[31:2])
            30'd0:   memf = W0;
            30'd1:   memf = W1;
            default: memf = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign imem_inst = memf(imem_addr);
    assign w_inst    = memf(w_addr);

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .misalign_err(misalign_err)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .rst(rst), .fetch_en(1'b1),
        .imem_addr(w_addr), .imem_inst(w_inst),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .out_valid(w_valid), .out_ready(1'b1),
        .out_inst(w_out_inst), .out_pc(w_out_pc), .out_pc_plus4(w_out_pc_plus4),
        .misalign_err(w_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fen;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [31:0] eaddr;
        logic        emis;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    function automatic vec_t mk(input logic r, input logic f, input logic rd, input logic rv,
                                input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                                input logic [31:0] einst, input logic [31:0] eaddr, input logic emis);
        vec_t v;
        v.rst = r; v.fen = f; v.rdy = rd; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.einst = einst; v.eaddr = eaddr; v.emis = emis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einst, input logic [31:0] eaddr, input logic emis);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".pc"}, out_pc, epc);
        chk({tag, ".inst"}, out_inst, einst);
        chk({tag, ".plus4"}, out_pc_plus4, epc + 32'd4);
        chk({tag, ".addr"}, imem_addr, eaddr);
        chk({tag, ".mis"}, {31'd0, misalign_err}, {31'd0, emis});
    endtask

    vec_t vecs[26];
    ent_t q[$];
    logic [31:0] mpc;
    logic        mmis;

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;

        // Wrap-around instance straight out of reset.
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("wrap0.valid", {31'd0, w_valid}, 32'd1);
        chk("wrap0.pc", w_out_pc, 32'hFFFF_FFFC);
        chk("wrap0.plus4", w_out_pc_plus4, 32'h0000_0000);
        chk("wrap0.inst", w_out_inst, 32'hC0DE_FFFC);
        tick();
        chk("wrap1.pc", w_out_pc, 32'h0000_0000);
        chk("wrap1.inst", w_out_inst, W0);
        chk("wrap1.plus4", w_out_pc_plus4, 32'h0000_0004);

        vecs[0]  = mk(1, 1, 1, 0, 32'h00, 0, 32'h00, NOP,           32'h00, 0);
        vecs[1]  = mk(0, 1, 1, 0, 32'h00, 1, 32'h00, W0,            32'h04, 0);
        vecs[2]  = mk(0, 1, 1, 0, 32'h00, 1, 32'h04, W1,            32'h08, 0);
        vecs[3]  = mk(1, 1, 1, 0, 32'h00, 0, 32'h00, NOP,           32'h00, 0);
        vecs[4]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h00, W0,            32'h04, 0);
        vecs[5]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h00, W0,            32'h08, 0);
        vecs[6]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h00, W0,            32'h08, 0);
        vecs[7]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h00, W0,            32'h08, 0);
        vecs[8]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h00, W0,            32'h08, 0);
        vecs[9]  = mk(0, 1, 1, 0, 32'h00, 1, 32'h04, W1,            32'h0C, 0);
        vecs[10] = mk(0, 1, 1, 0, 32'h00, 1, 32'h08, 32'hC0DE_0008, 32'h10, 0);
        vecs[11] = mk(0, 1, 1, 0, 32'h00, 1, 32'h0C, 32'hC0DE_000C, 32'h14, 0);
        vecs[12] = mk(0, 1, 0, 0, 32'h00, 1, 32'h0C, 32'hC0DE_000C, 32'h14, 0);
        vecs[13] = mk(0, 1, 0, 1, 32'h14, 0, 32'h00, NOP,           32'h14, 0);
        vecs[14] = mk(0, 1, 1, 0, 32'h00, 1, 32'h14, 32'hC0DE_0014, 32'h18, 0);
        vecs[15] = mk(0, 1, 1, 1, 32'h13, 0, 32'h00, NOP,           32'h10, 1);
        vecs[16] = mk(0, 1, 1, 0, 32'h00, 1, 32'h10, 32'hC0DE_0010, 32'h14, 0);
        vecs[17] = mk(0, 0, 0, 0, 32'h00, 1, 32'h10, 32'hC0DE_0010, 32'h14, 0);
        vecs[18] = mk(0, 0, 1, 0, 32'h00, 0, 32'h00, NOP,           32'h14, 0);
        vecs[19] = mk(0, 0, 1, 0, 32'h00, 0, 32'h00, NOP,           32'h14, 0);
        vecs[20] = mk(0, 1, 1, 0, 32'h00, 1, 32'h14, 32'hC0DE_0014, 32'h18, 0);
        vecs[21] = mk(1, 1, 1, 1, 32'h23, 0, 32'h00, NOP,           32'h00, 0);
        vecs[22] = mk(0, 1, 1, 0, 32'h00, 1, 32'h00, W0,            32'h04, 0);
        vecs[23] = mk(0, 1, 1, 1, 32'h40, 0, 32'h00, NOP,           32'h40, 0);
        vecs[24] = mk(0, 1, 1, 1, 32'h81, 0, 32'h00, NOP,           32'h80, 1);
        vecs[25] = mk(0, 1, 1, 0, 32'h00, 1, 32'h80, 32'hC0DE_0080, 32'h84, 0);

        for (int i = 0; i < 26; i++) begin
            rst = vecs[i].rst; fetch_en = vecs[i].fen; out_ready = vecs[i].rdy;
            redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
            tick();
            check_main($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc,
                       vecs[i].einst, vecs[i].eaddr, vecs[i].emis);
        end

        // Random traffic against the reference model.
        rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        tick();
        q.delete(); mpc = 32'h0000_0000; mmis = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic pop_m;
            logic push_m;
            ent_t hd;
            rst            = ($urandom_range(0, 99) == 0);
            fetch_en       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if (rst) begin
                q.delete(); mpc = 32'h0000_0000; mmis = 1'b0;
            end else begin
                pop_m  = (q.size() > 0) && out_ready && !redirect_valid;
                push_m = fetch_en && !redirect_valid && ((q.size() < 2) || pop_m);
                mmis   = redirect_valid && (redirect_pc % 4 != 0);
                if (redirect_valid) begin
                    q.delete();
                    mpc = redirect_pc - (redirect_pc % 4);
                end else begin
                    if (pop_m) void'(q.pop_front());
                    if (push_m) begin
                        q.push_back('{pc: mpc, inst: memf(mpc)});
                        mpc = mpc + 32'd4;
                    end
                end
            end
            tick();
            hd = (q.size() > 0) ? q[0] : '{pc: 32'h0, inst: NOP};
            check_main($sformatf("rnd%0d", c), q.size() > 0, hd.pc, hd.inst, mpc, mmis);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
